// File: rtl/de_pkg.sv
// Shared definitions for the decode stage: opcode values, instruction field
// positions and the per-opcode operand/writer decode.
package de_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MOV  = 4'd3;
    localparam logic [3:0] OP_LOAD = 4'd4;
    localparam logic [3:0] OP_LDI  = 4'd5;
    localparam logic [3:0] OP_BR   = 4'd6;
    localparam logic [3:0] OP_BRZ  = 4'd7;
    localparam logic [3:0] OP_BRN  = 4'd8;
    localparam logic [3:0] OP_CALL = 4'd9;
    localparam logic [3:0] OP_RET  = 4'd10;

    localparam int OP_LSB  = 20;
    localparam int RD_LSB  = 16;
    localparam int RA_LSB  = 12;
    localparam int RB_LSB  = 8;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 8;

    typedef struct packed {
        logic writer;
        logic readsA;
        logic readsB;
        logic illegal;
    } de_ctrl_t;

    function automatic de_ctrl_t decode_op(input logic [3:0] op);
        de_ctrl_t c;
        c = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                c.writer = 1'b1;
                c.readsA = 1'b1;
                c.readsB = 1'b1;
            end
            OP_MOV, OP_LOAD: begin
                c.writer = 1'b1;
                c.readsA = 1'b1;
            end
            OP_LDI: c.writer = 1'b1;
            OP_NOP, OP_BR, OP_BRZ, OP_BRN, OP_CALL, OP_RET: c = '0;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/de_regfile.sv
// NREG x DATA_W register file with two asynchronous read ports; a read of the
// register being written this cycle returns the incoming write data.
module de_regfile
    import de_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   we_i,
    input  logic [REG_AW-1:0]      waddr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [REG_AW-1:0]      raddrA_i,
    output logic [DATA_W-1:0]      rdataA_o,
    input  logic [REG_AW-1:0]      raddrB_i,
    output logic [DATA_W-1:0]      rdataB_o,
    output logic [NREG*DATA_W-1:0] dbgRegs_o
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic              writeOk;

    assign writeOk = we_i && (int'(waddr_i) < NREG);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (writeOk) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdataA_o = '0;
        rdataB_o = '0;
        if (int'(raddrA_i) < NREG) rdataA_o = regs_q[raddrA_i];
        if (int'(raddrB_i) < NREG) rdataB_o = regs_q[raddrB_i];
        if (writeOk && waddr_i == raddrA_i) rdataA_o = wdata_i;
        if (writeOk && waddr_i == raddrB_i) rdataB_o = wdata_i;
    end

    for (genvar g = 0; g < NREG; g++) begin : gDbg
        assign dbgRegs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: register file, hazard scoreboard, branch resolution and the
// registered DE/EX issue slot.
module decode_stage_p
    import de_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int ADDR_W = 8,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [23:0]            instr,
    input  logic [ADDR_W-1:0]      pc,
    input  logic                   wb_en,
    input  logic [REG_AW-1:0]      wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   z_in,
    input  logic                   n_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_op,
    output logic [REG_AW-1:0]      out_rd,
    output logic [DATA_W-1:0]      out_a,
    output logic [DATA_W-1:0]      out_b,
    output logic [DATA_W-1:0]      out_imm,
    output logic                   branch_taken,
    output logic [ADDR_W-1:0]      branch_target,
    output logic [ADDR_W-1:0]      lr_out,
    output logic                   illegal,
    output logic [NREG*DATA_W-1:0] dbg_regs
);

    logic [3:0]        op;
    logic [REG_AW-1:0] rd, ra, rb;
    logic [IMM_W-1:0]  imm;
    de_ctrl_t          ctrl;
    logic              unused_instr;

    assign op   = instr[OP_LSB +: 4];
    assign rd   = instr[RD_LSB +: REG_AW];
    assign ra   = instr[RA_LSB +: REG_AW];
    assign rb   = instr[RB_LSB +: REG_AW];
    assign imm  = instr[IMM_LSB +: IMM_W];
    assign ctrl = decode_op(op);
    assign unused_instr = ^instr;

    logic [DATA_W-1:0] rdataA, rdataB;

    de_regfile #(.DATA_W(DATA_W), .NREG(NREG)) uRegfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddrA_i (ra),
        .rdataA_o (rdataA),
        .raddrB_i (rb),
        .rdataB_o (rdataB),
        .dbgRegs_o(dbg_regs)
    );

    logic                 outValid_q;
    logic [3:0]           outOp_q;
    logic [REG_AW-1:0]    outRd_q;
    logic [DATA_W-1:0]    outA_q, outB_q, outImm_q;
    logic                 branchTaken_q, illegal_q;
    logic [ADDR_W-1:0]    branchTarget_q, lr_q;
    logic [NREG-1:0]      pending_q, pending_d;
    logic [NREG-1:0]      wbHit, slotBusy, hazard;

    // A writer still sitting in the slot has not set its pending bit yet, so
    // its destination is treated as busy to keep readers from seeing stale data.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wbHit[r]    = wb_en && (int'(wb_addr) == r);
            slotBusy[r] = outValid_q && (int'(outRd_q) == r);
        end
        hazard = (pending_q & ~wbHit) | slotBusy;
    end

    logic shadow, live, stall, accept, doExec, takeBranch;
    logic [ADDR_W-1:0] target;

    // The cycle right after a taken branch is exactly when branch_taken is high.
    assign shadow   = branchTaken_q;
    assign live     = in_valid && !shadow && !ctrl.illegal;
    assign stall    = live && ((ctrl.readsA && hazard[ra]) ||
                               (ctrl.readsB && hazard[rb]) ||
                               (ctrl.writer && hazard[rd]));
    assign in_ready = !stall && (!outValid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign doExec   = accept && !shadow && !ctrl.illegal;

    always_comb begin
        takeBranch = 1'b0;
        if (doExec) begin
            case (op)
                OP_BR, OP_CALL, OP_RET: takeBranch = 1'b1;
                OP_BRZ:                 takeBranch = z_in;
                OP_BRN:                 takeBranch = n_in;
                default:                takeBranch = 1'b0;
            endcase
        end
        target = (op == OP_RET) ? lr_q : imm[ADDR_W-1:0];
    end

    // Set beats clear when the issuing writer and the write-back share a register.
    always_comb begin
        pending_d = pending_q & ~wbHit;
        if (outValid_q && out_ready) pending_d = pending_d | slotBusy;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValid_q     <= 1'b0;
            outOp_q        <= '0;
            outRd_q        <= '0;
            outA_q         <= '0;
            outB_q         <= '0;
            outImm_q       <= '0;
            branchTaken_q  <= 1'b0;
            branchTarget_q <= '0;
            lr_q           <= '0;
            illegal_q      <= 1'b0;
            pending_q      <= '0;
        end else begin
            pending_q     <= pending_d;
            branchTaken_q <= takeBranch;
            illegal_q     <= accept && !shadow && ctrl.illegal;
            if (takeBranch) branchTarget_q <= target;
            if (doExec && op == OP_CALL) lr_q <= pc + ADDR_W'(1);
            if (doExec && (ctrl.writer || op == OP_NOP)) begin
                outValid_q <= ctrl.writer;
                outOp_q    <= op;
                outRd_q    <= rd;
                outA_q     <= rdataA;
                outB_q     <= rdataB;
                outImm_q   <= DATA_W'(imm);
            end else if (out_ready) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign out_valid     = outValid_q;
    assign out_op        = outOp_q;
    assign out_rd        = outRd_q;
    assign out_a         = outA_q;
    assign out_b         = outB_q;
    assign out_imm       = outImm_q;
    assign branch_taken  = branchTaken_q;
    assign branch_target = branchTarget_q;
    assign lr_out        = lr_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: issued instructions are predicted into a queue
// when driven and compared by a monitor when they leave the DE/EX slot.
module tb_decode_stage_p;

    localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_MOV = 4'd3, OP_LDI = 4'd5;
    localparam logic [3:0] OP_BRZ = 4'd7, OP_BRN = 4'd8, OP_CALL = 4'd9, OP_RET = 4'd10;

    logic        clk, reset_n, in_valid, in_ready, wb_en, z_in, n_in;
    logic [23:0] instr;
    logic [7:0]  pc, wb_data, out_a, out_b, out_imm, branch_target, lr_out;
    logic [1:0]  wb_addr, out_rd;
    logic        out_valid, out_ready, branch_taken, illegal;
    logic [3:0]  out_op;
    logic [31:0] dbg_regs;

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [7:0] a, b, imm;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] model[4];
    int         nChecks = 0;
    int         nFails  = 0;

    decode_stage_p dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .z_in(z_in), .n_in(n_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
        .branch_taken(branch_taken), .branch_target(branch_target), .lr_out(lr_out),
        .illegal(illegal), .dbg_regs(dbg_regs)
    );

    always #5 clk = ~clk;

    // Every completed DE/EX transfer must match the oldest prediction.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            nChecks++;
            if (expQ.size() == 0) begin
                nFails++;
                $display("[TB] FAIL unexpected_issue: got op=%0d rd=%0d, expected no issue", out_op, out_rd);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if ({out_op, out_rd, out_a, out_b, out_imm} !== {e.op, e.rd, e.a, e.b, e.imm}) begin
                    nFails++;
                    $display("[TB] FAIL issue: got op=%0d rd=%0d a=%h b=%h imm=%h, expected op=%0d rd=%0d a=%h b=%h imm=%h",
                             out_op, out_rd, out_a, out_b, out_imm, e.op, e.rd, e.a, e.b, e.imm);
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input int rd, input int ra, input int rb,
                                 input logic [7:0] imm);
        in_valid = 1'b1;
        instr    = {op, 4'(rd), 4'(ra), 4'(rb), imm};
    endtask

    task automatic idle();
        in_valid = 1'b0;
        wb_en    = 1'b0;
    endtask

    task automatic writeBack(input int r, input logic [7:0] d);
        wb_en    = 1'b1;
        wb_addr  = 2'(r);
        wb_data  = d;
        model[r] = d;
    endtask

    task automatic pushExp(input logic [3:0] op, input int rd, input int ra, input int rb,
                           input logic [7:0] imm);
        exp_t e;
        e.op  = op;
        e.rd  = 2'(rd);
        e.a   = model[ra];
        e.b   = model[rb];
        e.imm = imm;
        expQ.push_back(e);
    endtask

    task automatic test_reset();
        #2;
        @(negedge clk);
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rst_out_valid: got %b, expected 0", out_valid); end
        nChecks++; if ({out_op, out_rd, out_a, out_b, out_imm} !== '0) begin nFails++; $display("[TB] FAIL rst_out_fields: got %h, expected 0", {out_op, out_rd, out_a, out_b, out_imm}); end
        nChecks++; if ({branch_taken, branch_target, illegal} !== '0) begin nFails++; $display("[TB] FAIL rst_branch: got %h, expected 0", {branch_taken, branch_target, illegal}); end
        nChecks++; if (lr_out !== 8'h00) begin nFails++; $display("[TB] FAIL rst_lr: got %h, expected 00", lr_out); end
        nChecks++; if (dbg_regs !== 32'h0) begin nFails++; $display("[TB] FAIL rst_regs: got %h, expected 0", dbg_regs); end
        #2 reset_n = 1'b1;
    endtask

    task automatic test_ldi_wb();
        nextCycle(); applyStimulus(OP_LDI, 3, 0, 0, 8'hE7); pushExp(OP_LDI, 3, 0, 0, 8'hE7);
        @(negedge clk);
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL ldi_ready: got %b, expected 1", in_ready); end
        nextCycle(); idle();
        @(negedge clk);
        nChecks++; if ({out_valid, out_rd, out_imm} !== {1'b1, 2'd3, 8'hE7}) begin nFails++; $display("[TB] FAIL ldi_issue: got v=%b rd=%0d imm=%h, expected v=1 rd=3 imm=e7", out_valid, out_rd, out_imm); end
        nextCycle(); writeBack(3, 8'hE7);
        @(negedge clk);
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL ldi_drain: got %b, expected 0", out_valid); end
        nextCycle(); idle();
        @(negedge clk);
        nChecks++; if (dbg_regs[31:24] !== 8'hE7) begin nFails++; $display("[TB] FAIL ldi_wb_reg: got %h, expected e7", dbg_regs[31:24]); end
    endtask

    task automatic test_stall_bypass();
        nextCycle(); applyStimulus(OP_LDI, 2, 0, 0, 8'h33); pushExp(OP_LDI, 2, 0, 0, 8'h33);
        nextCycle(); idle();
        for (int k = 0; k < 2; k++) begin
            nextCycle(); applyStimulus(OP_ADD, 1, 0, 2, 8'h00);
            @(negedge clk);
            nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL stall_%0d: got in_ready=%b, expected 0", k, in_ready); end
        end
        nextCycle(); writeBack(2, 8'h07); pushExp(OP_ADD, 1, 0, 2, 8'h00);
        @(negedge clk);
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL bypass_ready: got %b, expected 1", in_ready); end
        nextCycle(); idle();
        @(negedge clk);
        nChecks++; if ({out_valid, out_b} !== {1'b1, 8'h07}) begin nFails++; $display("[TB] FAIL bypass_b: got v=%b b=%h, expected v=1 b=07", out_valid, out_b); end
        nextCycle(); writeBack(1, 8'h07);
        nextCycle(); idle();
    endtask

    task automatic test_backpressure();
        nextCycle(); applyStimulus(OP_MOV, 2, 3, 0, 8'h00); pushExp(OP_MOV, 2, 3, 0, 8'h00);
        nextCycle(); out_ready = 1'b0; applyStimulus(OP_LDI, 0, 0, 0, 8'h55);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) nextCycle();
            @(negedge clk);
            nChecks++;
            if ({out_valid, out_op, out_rd, out_a, in_ready} !== {1'b1, OP_MOV, 2'd2, 8'hE7, 1'b0}) begin
                nFails++;
                $display("[TB] FAIL hold_%0d: got v=%b op=%0d rd=%0d a=%h rdy=%b, expected v=1 op=3 rd=2 a=e7 rdy=0",
                         k, out_valid, out_op, out_rd, out_a, in_ready);
            end
        end
        nextCycle(); out_ready = 1'b1; pushExp(OP_LDI, 0, 0, 0, 8'h55);
        @(negedge clk);
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL release_ready: got %b, expected 1", in_ready); end
        nextCycle(); idle();
        nextCycle(); writeBack(2, 8'hE7);
        nextCycle(); writeBack(0, 8'h55);
        nextCycle(); idle();
    endtask

    task automatic test_branch();
        nextCycle(); pc = 8'h05; z_in = 1'b1; applyStimulus(OP_BRZ, 0, 0, 0, 8'h10);
        nextCycle(); pc = 8'h06; applyStimulus(OP_ADD, 1, 0, 2, 8'h00);
        @(negedge clk);
        nChecks++; if ({branch_taken, branch_target} !== {1'b1, 8'h10}) begin nFails++; $display("[TB] FAIL brz_taken: got t=%b tgt=%h, expected t=1 tgt=10", branch_taken, branch_target); end
        nextCycle(); idle(); z_in = 1'b0;
        @(negedge clk);
        nChecks++; if ({branch_taken, out_valid} !== 2'b00) begin nFails++; $display("[TB] FAIL brz_squash: got t=%b v=%b, expected 0 0", branch_taken, out_valid); end
        nextCycle(); pc = 8'h05; applyStimulus(OP_BRZ, 0, 0, 0, 8'h10);
        nextCycle(); pc = 8'h06; applyStimulus(OP_ADD, 1, 0, 2, 8'h00); pushExp(OP_ADD, 1, 0, 2, 8'h00);
        @(negedge clk);
        nChecks++; if ({branch_taken, in_ready} !== 2'b01) begin nFails++; $display("[TB] FAIL brz_not_taken: got t=%b rdy=%b, expected t=0 rdy=1", branch_taken, in_ready); end
        nextCycle(); idle();
        nextCycle(); writeBack(1, 8'h3C);
        nextCycle(); idle(); n_in = 1'b1; applyStimulus(OP_BRN, 0, 0, 0, 8'h44);
        nextCycle(); idle(); n_in = 1'b0;
        @(negedge clk);
        nChecks++; if ({branch_taken, branch_target} !== {1'b1, 8'h44}) begin nFails++; $display("[TB] FAIL brn_taken: got t=%b tgt=%h, expected t=1 tgt=44", branch_taken, branch_target); end
    endtask

    task automatic test_call_ret();
        nextCycle(); pc = 8'h07; applyStimulus(OP_CALL, 0, 0, 0, 8'h20);
        nextCycle(); pc = 8'h08; applyStimulus(OP_NOP, 0, 0, 0, 8'h00);
        @(negedge clk);
        nChecks++; if ({branch_taken, branch_target, lr_out} !== {1'b1, 8'h20, 8'h08}) begin nFails++; $display("[TB] FAIL call: got t=%b tgt=%h lr=%h, expected t=1 tgt=20 lr=08", branch_taken, branch_target, lr_out); end
        nextCycle(); pc = 8'h09; applyStimulus(OP_RET, 0, 0, 0, 8'h00);
        @(negedge clk);
        nChecks++; if ({branch_taken, out_valid} !== 2'b00) begin nFails++; $display("[TB] FAIL call_shadow: got t=%b v=%b, expected 0 0", branch_taken, out_valid); end
        nextCycle(); idle();
        @(negedge clk);
        nChecks++; if ({branch_taken, branch_target} !== {1'b1, 8'h08}) begin nFails++; $display("[TB] FAIL ret: got t=%b tgt=%h, expected t=1 tgt=08", branch_taken, branch_target); end
        nextCycle(); applyStimulus(4'hC, 1, 0, 0, 8'h00);
        nextCycle(); idle();
        @(negedge clk);
        nChecks++; if ({illegal, out_valid} !== 2'b10) begin nFails++; $display("[TB] FAIL illegal_pulse: got ill=%b v=%b, expected ill=1 v=0", illegal, out_valid); end
        nextCycle();
        @(negedge clk);
        nChecks++; if (illegal !== 1'b0) begin nFails++; $display("[TB] FAIL illegal_clear: got %b, expected 0", illegal); end
    endtask

    task automatic test_back_to_back();
        nextCycle(); pc = 8'h10; applyStimulus(OP_CALL, 0, 0, 0, 8'h30);
        nextCycle(); pc = 8'h11; applyStimulus(OP_RET, 0, 0, 0, 8'h00);
        @(negedge clk);
        nChecks++; if ({branch_taken, branch_target, lr_out} !== {1'b1, 8'h30, 8'h11}) begin nFails++; $display("[TB] FAIL b2b_call: got t=%b tgt=%h lr=%h, expected t=1 tgt=30 lr=11", branch_taken, branch_target, lr_out); end
        nextCycle(); idle();
        @(negedge clk);
        nChecks++; if (branch_taken !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_ret_squash: got %b, expected 0", branch_taken); end
        nextCycle(); applyStimulus(OP_LDI, 2, 0, 0, 8'hA1); pushExp(OP_LDI, 2, 0, 0, 8'hA1);
        nextCycle(); applyStimulus(OP_LDI, 3, 0, 0, 8'hB2); pushExp(OP_LDI, 3, 0, 0, 8'hB2);
        @(negedge clk);
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_ldi_ready: got %b, expected 1", in_ready); end
        nextCycle(); idle();
        nextCycle(); writeBack(2, 8'hA1);
        nextCycle(); writeBack(3, 8'hB2);
        nextCycle(); idle();
    endtask

    task automatic test_reset_mid_stall();
        nextCycle(); applyStimulus(OP_LDI, 1, 0, 0, 8'h99); pushExp(OP_LDI, 1, 0, 0, 8'h99);
        nextCycle(); idle();
        nextCycle(); applyStimulus(OP_ADD, 2, 1, 0, 8'h00);
        @(negedge clk);
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL mid_stall: got %b, expected 0", in_ready); end
        #2 reset_n = 1'b0;
        #1;
        nChecks++; if ({out_valid, out_op, out_rd, out_a, out_b, out_imm} !== '0) begin nFails++; $display("[TB] FAIL async_rst_out: got %h, expected 0", {out_valid, out_op, out_rd, out_a, out_b, out_imm}); end
        nChecks++; if ({branch_taken, branch_target, lr_out, illegal} !== '0) begin nFails++; $display("[TB] FAIL async_rst_ctl: got %h, expected 0", {branch_taken, branch_target, lr_out, illegal}); end
        nChecks++; if (dbg_regs !== 32'h0) begin nFails++; $display("[TB] FAIL async_rst_regs: got %h, expected 0", dbg_regs); end
        idle();
        for (int r = 0; r < 4; r++) model[r] = 8'h00;
        @(negedge clk);
        #2 reset_n = 1'b1;
        nextCycle(); applyStimulus(OP_ADD, 2, 1, 0, 8'h00); pushExp(OP_ADD, 2, 1, 0, 8'h00);
        @(negedge clk);
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL post_rst_ready: got %b, expected 1", in_ready); end
        nextCycle(); idle();
        @(negedge clk);
        nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("[TB] FAIL post_rst_issue: got %b, expected 1", out_valid); end
        nextCycle();
    endtask

    initial begin
        clk = 1'b0; reset_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; z_in = 1'b0; n_in = 1'b0; out_ready = 1'b1;
        for (int r = 0; r < 4; r++) model[r] = 8'h00;
        test_reset();
        test_ldi_wb();
        test_stall_bypass();
        test_backpressure();
        test_branch();
        test_call_ret();
        test_back_to_back();
        test_reset_mid_stall();
        nextCycle();
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL pending_expectations: got %0d left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/decode_stage_p.md
# decode_stage_p

Parametrised decode stage for the RISC pipeline: holds the NREG x DATA_W register file and link register, decodes 24-bit instructions, resolves branches/calls/returns from the EX flags, and issues operands into a registered DE/EX slot with valid/ready handshakes. A per-register scoreboard stalls issue on hazards against in-flight writers, and a write-back bypass makes same-cycle write-back data visible to the instruction reading it.

## Interface
- DATA_W, 8, register/data width (>= 8)
- NREG, 4, register count (2..16); REG_AW = clog2(NREG)
- ADDR_W, 8, instruction address width (<= 8)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid / in_ready  in / out  1  FE/DE handshake
- instr  in  24  op[23:20], rd[19:16], ra[15:12], rb[11:8], imm[7:0]
- pc  in  ADDR_W  address of instr
- wb_en, wb_addr, wb_data  in  1 / REG_AW / DATA_W  write-back port
- z_in, n_in  in  1  flags of the last executed ALU op
- out_valid / out_ready  out / in  1  DE/EX handshake
- out_op, out_rd  out  4 / REG_AW  issued opcode, destination
- out_a, out_b, out_imm  out  DATA_W  operands; imm zero-extended
- branch_taken  out  1  one-cycle redirect pulse
- branch_target  out  ADDR_W  redirect address
- lr_out  out  ADDR_W  link register
- illegal  out  1  one-cycle pulse on an undefined opcode
- dbg_regs  out  NREG*DATA_W  flat register view, R0 in the LSBs

## Operation
- Opcodes: NOP 0, ADD 1, SUB 2, MOV 3, LOAD 4, LDI 5, BR 6, BRZ 7, BRN 8, CALL 9, RET 10. Opcodes 11-15 are treated as NOP and pulse illegal.
- Register fields are truncated to REG_AW bits.
- Writers: ADD, SUB, MOV, LOAD, LDI. Readers: ADD/SUB read ra and rb; MOV and LOAD read ra.
- Scoreboard: one pending bit per register.
  - Set when a writer issues (out_valid && out_ready).
  - Cleared by wb_en at wb_addr.
  - If set and clear hit the same register in the same cycle, set wins.
- Stall: an instruction is held if any source or its rd is pending, unless the only pending reason is a write-back on that register this cycle. In that case wb_data is bypassed into the operand.
- Read of a register written the same cycle returns wb_data (write-through).
- in_ready = !stall && (!out_valid || out_ready).
- Accepting a writer or NOP loads the DE/EX slot. NOP issues a bubble: out_valid stays 0.
- Branches never occupy the DE/EX slot.
  - BR, CALL: always taken, target imm[ADDR_W-1:0]. CALL also loads lr <= pc+1, modulo 2^ADDR_W.
  - BRZ is taken iff z_in; BRN is taken iff n_in, sampled in the acceptance cycle.
  - RET: target is lr.
- Shadow: the instruction accepted in the cycle after a taken branch is squashed. It is consumed, not issued, and sets no scoreboard bit.
- Illegal opcode: illegal pulses, nothing issues, no state changes.

## Timing
- Reset values, all zero: registers, lr, pending bits, out_* (including out_valid), branch_taken, branch_target, illegal. Reset applies asynchronously at any point, including mid-stall; the shadow flag also clears.
- Issue latency: 1 cycle from acceptance to out_valid.
- branch_taken and branch_target are registered and valid for exactly 1 cycle after acceptance.
- Write-back updates the register file at the clock edge. dbg_regs shows the new value in the following cycle.
- While out_valid && !out_ready, all out_* hold stable.
- CALL followed directly by RET: the RET falls in the shadow and is squashed.

## Structure
- Shared package de_pkg: opcode localparams, field bit positions, and an is_writer/reads_a/reads_b decode function.
- Sub-module de_regfile:
  - NREG x DATA_W, two asynchronous read ports, one write port with write-through bypass.
  - Asynchronous active-low reset to zero; exports dbg_regs.
- Scoreboard, branch unit and DE/EX register live in the top module.

## Test plan
- Reset, then LDI r3,0xE7 followed by wb r3=0xE7 -> out_imm=0xE7 and out_rd=3 one cycle after accept; dbg_regs[31:24]=0xE7 after the wb edge.
- ADD r1←r0,r2 with r2 pending, wb r2=0x07 two cycles later -> in_ready low until the wb cycle; issues with out_b=0x07 via bypass in that cycle.
- out_ready held low for 3 cycles with out_valid high -> out_* unchanged, in_ready low; releases on the 4th cycle.
- BRZ imm=0x10 with z_in=1 at pc=0x05, next instr ADD -> branch_taken pulse, target 0x10; ADD squashed, no out_valid. Repeat with z_in=0 -> no pulse, ADD issues.
- CALL 0x20 at pc=0x07, then NOP, then RET -> lr_out=0x08; RET redirects to 0x08. Opcode 0xC -> illegal pulse, no issue.
- Assert reset_n low mid-stall with r1 pending -> all outputs zero immediately; after release, ADD reading r1 issues without stall.
